// File: rtl/uart_buffer_pkg.sv
// Shared sizing for the UART RX/TX byte buffers.
// Holds the default FIFO depth, pointer width and the UART byte width.
package uart_buffer_pkg;

    localparam int DATA_W      = 8;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;

    typedef logic [DATA_W-1:0] uartByte_t;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO storage with head/tail pointers.
// Synchronous write at the tail, first-word-fall-through read at the head.
// Pointers are ADDR_W bits wide, so they wrap modulo DEPTH on their own.
// The caller decides when a write or pop is legal; no checking is done here.
module uart_fifo
    import uart_buffer_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  uartByte_t         wrData,
    input  logic              rdEn,
    output uartByte_t         rdData
);

    uartByte_t         mem [DEPTH];
    logic [ADDR_W-1:0] headPtr;
    logic [ADDR_W-1:0] tailPtr;

    // Pointer advance on accepted write/pop; cleared asynchronously by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headPtr <= '0;
            tailPtr <= '0;
        end else begin
            if (wrEn) tailPtr <= tailPtr + 1'b1;
            if (rdEn) headPtr <= headPtr + 1'b1;
        end
    end

    // Storage array, not reset: contents are only visible through the count.
    always_ff @(posedge clk) begin
        if (wrEn) mem[tailPtr] <= wrData;
    end

    assign rdData = mem[headPtr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Receive-side byte buffer between the UART receiver and a consumer.
// Adds push/pop handshake, occupancy count and status flags on top of
// uart_fifo. All status outputs derive from the registered count.
// Optional overflow sticky flag: define UART_RX_BUFFER_OVERRUN_EN to add
// the overrun/overrunClr ports; otherwise overflow bytes vanish silently.
module uart_rx_buffer
    import uart_buffer_pkg::*;
#(
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rxData,
    input  logic              rxDone,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataValid,
    input  logic              dataRead,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
`ifdef UART_RX_BUFFER_OVERRUN_EN
    ,
    output logic              overrun,
    input  logic              overrunClr
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    logic      pop;
    logic      push;
    uartByte_t fifoHead;

    assign empty     = (count == '0);
    assign full      = (count == FULL_COUNT);
    assign dataValid = ~empty;

    // A pop frees a slot in the same edge, so a full FIFO still takes a byte
    // when it is read at the same time.
    assign pop  = dataRead & ~empty;
    assign push = rxDone & (~full | pop);

    // Hide stale storage while nothing is held.
    assign dataOut = empty ? '0 : fifoHead;

    uart_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (push),
        .wrData (rxData),
        .rdEn   (pop),
        .rdData (fifoHead)
    );

    // Occupancy count: +1 on push only, -1 on pop only, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + 1'b1;
        end else if (pop && !push) begin
            count <= count - 1'b1;
        end
    end

`ifdef UART_RX_BUFFER_OVERRUN_EN
    logic drop;

    assign drop = rxDone & full & ~pop;

    // Sticky overflow flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrunClr) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/uart_rx_buffer.md
UART_RX_BUFFER -- requirements
Module: uart_rx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter ADDR_W, default 4, log2(DEPTH).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port rxData  input  8  byte from the UART receiver; valid only while rxDone=1.
REQ-006 SHALL have port rxDone  input  1  one-cycle strobe from the receiver: rxData holds a received byte.
REQ-007 SHALL have port dataOut  output  8  head-of-FIFO byte, first-word-fall-through.
REQ-008 SHALL have port dataValid  output  1  high while the FIFO holds at least one byte.
REQ-009 SHALL have port dataRead  input  1  consumer pop strobe; one byte consumed per cycle it is high with dataValid=1.
REQ-010 SHALL have port empty  output  1  count==0.
REQ-011 SHALL have port full  output  1  count==DEPTH.
REQ-012 SHALL have port count  output  ADDR_W+1  number of stored bytes, 0..DEPTH.

Function
REQ-013 SHALL write rxData at the tail on a clk edge with rxDone=1 and either full=0 or a simultaneous accepted pop.
REQ-014 SHALL assert dataValid and present the byte on dataOut in the cycle after the write into an empty FIFO (latency 1).
REQ-015 SHALL advance the head on a clk edge with dataRead=1 and dataValid=1; dataOut shows the next byte in the following cycle.
REQ-016 SHALL ignore dataRead while dataValid=0 (no pointer or count change).
REQ-017 SHALL, on simultaneous accepted write and pop, leave count unchanged, including at count==DEPTH.
REQ-018 SHALL, with rxDone=1 and empty=1 and dataRead=1, store the byte and ignore the read.
REQ-019 SHALL, with rxDone=1, full=1 and no pop, discard the byte and leave contents, pointers and count unchanged.
REQ-020 SHALL wrap head and tail pointers modulo DEPTH without disturbing ordering.
REQ-021 SHALL preserve strict byte order (FIFO).
REQ-022 SHALL hold dataOut stable while dataValid=1 and no pop occurs.
REQ-023 SHALL drive empty, full, dataValid and count from registered state only (no combinational path from rxDone/dataRead).

Reset
REQ-024 SHALL, on rst=1, asynchronously clear head, tail and count; dataValid=0, empty=1, full=0, count=0, dataOut=8'h00.
REQ-025 SHALL discard all stored bytes when rst asserts mid-operation; rxDone and dataRead are ignored while rst=1.
REQ-026 SHALL accept a write on the first clk edge after rst deasserts.

Configuration
REQ-027 SHALL, with UART_RX_BUFFER_OVERRUN_EN defined, add ports overrun (output 1) and overrunClr (input 1).
REQ-028 SHALL, with the macro, set overrun on the edge where a byte is discarded per REQ-019; overrun stays set until overrunClr=1 or rst.
REQ-029 SHALL, with the macro, give set priority over overrunClr in the same cycle.
REQ-030 SHALL, without the macro, omit both ports and drop overflow bytes silently; all other behaviour identical.

Structure
REQ-031 SHALL take the DEPTH/ADDR_W defaults and the byte width (8) from shared package uart_buffer_pkg, also used by uart_tx_buffer.
REQ-032 SHALL implement storage and pointers in one sub-module uart_fifo (synchronous write, FWFT read); uart_rx_buffer adds handshake, status and overrun logic.

Verification
REQ-033 SHALL verify: rst, then rxDone with 8'h41 -> dataValid=1 and dataOut=8'h41 next cycle, count=1; dataRead pop -> empty=1.
REQ-034 SHALL verify: write 8'h41..8'h50 (16 bytes), no reads -> full=1, count=16; 17th byte 8'h51 dropped; reads return 8'h41..8'h50 in order.
REQ-035 SHALL verify: at full, rxDone=8'h60 with dataRead in same cycle -> count stays 16, 8'h60 returned last.
REQ-036 SHALL verify: 40 bytes through with interleaved reads (pointer wrap twice) -> output sequence equals input sequence.
REQ-037 SHALL verify: rst asserted asynchronously (between edges) with count=5 -> empty=1, count=0, dataValid=0 immediately.
REQ-038 SHALL verify (macro defined): overflow sets overrun=1; overrunClr pulse clears it; overflow coinciding with overrunClr leaves overrun=1.
